hack_bit: RTL and testbench
===========================

Name: hack_bit

Overview:
- Single-bit storage register with load enable: the Hack "Bit" primitive (DFF plus feedback mux).
- Base cell from which the Hack Register, RAM and PC blocks are built.
- On each rising clock edge, out captures in when enable is high; otherwise out holds its value.
- Asynchronous active-high reset clears the stored bit.

Parameters:
- WIDTH, 1, stored word width in bits.
  - Default 1 is the Hack Bit.
  - Wider values give a plain N-bit load register with identical semantics on every bit.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; clears out to 0.
- in  input  WIDTH  data to be stored.
- enable  input  1  load strobe (Hack "load"); 1 = capture in at next rising clk edge.
- out  output  WIDTH  current stored value; registered, no combinational path from in or enable.
- Declaration order is fixed as in, enable, clk, out, rst so that existing positional instantiations (in, enable, clk, out) remain valid.
  - rst is appended last.
  - If rst is left unconnected it must be tied inactive (0) inside the module; implement it as a port with default 0 or document the tie-off.

Behaviour:
- Reset:
  - rst=1 forces out=0 immediately, without waiting for clk, and holds it at 0 while asserted.
  - Deassertion is synchronised by the user; the first capture can occur on the first rising clk after rst falls.
- Load: at rising clk with rst=0 and enable=1, out <= in. Latency is one edge: the new value is visible after that edge and stays stable for the whole following cycle.
- Hold: at rising clk with enable=0, out keeps its previous value regardless of in.
- Between edges, changes on in or enable never affect out.
- Simultaneous events: if rst=1 at a clk edge, reset wins and out=0 regardless of enable/in.
- Power-up without reset: out is undefined (X in simulation) until the first load or reset. Simulation models must not silently initialise to 0.
- Structure: conceptually out_next = enable ? in : out, fed into a D flip-flop with async clear.
  - No latches.
  - No gated clock; enable acts through the data mux only.
- WIDTH>1: each bit behaves identically and independently; all bits share enable, clk and rst.

Test Plan:
- Reset: assert rst mid-cycle with out=1 -> out goes 0 immediately without a clk edge. Hold rst=1 with enable=1, in=1 across an edge -> out stays 0.
- Load 0 then 1: in=0, enable=1, edge -> out=0. Then in=1, enable=0, edge -> out stays 0. Then enable=1, edge -> out=1.
- Hold against toggling input: out=1, enable=0. Apply in=0, edge, then in=1, edge -> out stays 1 throughout.
- Consecutive loads: enable=1, in sequence 0,1,0 on three edges -> out sequence 0,1,0, each visible only after its edge.
- Mid-cycle glitch: with enable=0, pulse enable and in between edges, returning to enable=0 before the edge -> out unchanged.
- WIDTH=4: rst, then enable=1, in=4'b1010, edge -> out=4'b1010. Then enable=0, in=4'b0101, edge -> out stays 4'b1010.

Source files
------------

// File: rtl/hack_bit.sv
// hack_bit: Hack "Bit" storage cell -- a D flip-flop with async clear fed by
// an enable-controlled feedback mux. WIDTH>1 gives a plain N-bit load register.
//
// Port order (in, enable, clk, out, rst) keeps legacy positional instances
// of the four-port Bit valid. rst was appended for reset support. A
// positional instance that stops after out leaves rst floating, so such
// instances must tie rst to 1'b0 explicitly. Synthesis ties an unconnected
// input to 0, but simulation would see Z.
//
// The flop has no power-up initialiser. Simulation therefore shows X until
// the first load or reset.
module hack_bit #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  input  logic             clk,
  output logic [WIDTH-1:0] out,
  input  logic             rst
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Feedback mux: load in on enable, otherwise recirculate the stored word.
  always_comb begin
    out_d = out_q;
    if (enable) begin
      out_d = in;
    end
  end

  // Storage flop with asynchronous active-high clear; reset wins over load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= WIDTH'(0);
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_hack_bit.sv
// tb_hack_bit: directed checks of hack_bit at WIDTH=1 and WIDTH=4.
module tb_hack_bit;

  logic       clk;
  logic       rst;
  logic       in1;
  logic       en1;
  logic       out1;
  logic [3:0] in4;
  logic       en4;
  logic [3:0] out4;

  int checks   = 0;
  int failures = 0;

  hack_bit #(.WIDTH(1)) u_bit1 (
    .in     (in1),
    .enable (en1),
    .clk    (clk),
    .out    (out1),
    .rst    (rst)
  );

  hack_bit #(.WIDTH(4)) u_bit4 (
    .in     (in4),
    .enable (en4),
    .clk    (clk),
    .out    (out4),
    .rst    (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Wait for the active edge, then sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in1 = 1'b0;
    en1 = 1'b0;
    in4 = 4'b0000;
    en4 = 1'b0;

    // Reset asserted without a clock edge clears both registers.
    #2 rst = 1'b1;
    #1;
    check("reset_async_w1", {3'b000, out1}, 4'b0000);
    check("reset_async_w4", out4, 4'b0000);

    // Reset held across an edge beats a pending load.
    en1 = 1'b1; in1 = 1'b1;
    en4 = 1'b1; in4 = 4'b1111;
    tick();
    check("reset_hold_w1", {3'b000, out1}, 4'b0000);
    check("reset_hold_w4", out4, 4'b0000);

    @(negedge clk);
    rst = 1'b0;
    en4 = 1'b0;

    // Load 0, hold with in=1, then load 1.
    in1 = 1'b0; en1 = 1'b1;
    tick();
    check("load0", {3'b000, out1}, 4'b0000);
    @(negedge clk);
    in1 = 1'b1; en1 = 1'b0;
    tick();
    check("hold_after_load0", {3'b000, out1}, 4'b0000);
    @(negedge clk);
    en1 = 1'b1;
    tick();
    check("load1", {3'b000, out1}, 4'b0001);

    // Mid-cycle reset with out=1 clears immediately.
    @(negedge clk);
    en1 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_midcycle", {3'b000, out1}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    in1 = 1'b1; en1 = 1'b1;
    tick();
    check("reload1", {3'b000, out1}, 4'b0001);

    // Hold against a toggling input.
    @(negedge clk);
    en1 = 1'b0; in1 = 1'b0;
    tick();
    check("hold_in0", {3'b000, out1}, 4'b0001);
    @(negedge clk);
    in1 = 1'b1;
    tick();
    check("hold_in1", {3'b000, out1}, 4'b0001);

    // Glitch on enable/in between edges leaves out unchanged.
    @(negedge clk);
    #1 en1 = 1'b1; in1 = 1'b0;
    #1;
    check("glitch_between_edges", {3'b000, out1}, 4'b0001);
    #1 en1 = 1'b0;
    tick();
    check("glitch_after_edge", {3'b000, out1}, 4'b0001);

    // Consecutive loads 0,1,0: each visible only after its edge.
    @(negedge clk);
    en1 = 1'b1; in1 = 1'b0;
    #1;
    check("seq0_pre_edge", {3'b000, out1}, 4'b0001);
    tick();
    check("seq0", {3'b000, out1}, 4'b0000);
    @(negedge clk);
    in1 = 1'b1;
    #1;
    check("seq1_pre_edge", {3'b000, out1}, 4'b0000);
    tick();
    check("seq1", {3'b000, out1}, 4'b0001);
    @(negedge clk);
    in1 = 1'b0;
    #1;
    check("seq2_pre_edge", {3'b000, out1}, 4'b0001);
    tick();
    check("seq2", {3'b000, out1}, 4'b0000);

    // WIDTH=4: reset, load 1010, then hold against 0101.
    @(negedge clk);
    en1 = 1'b0;
    rst = 1'b1;
    #1;
    check("w4_reset", out4, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    en4 = 1'b1; in4 = 4'b1010;
    tick();
    check("w4_load", out4, 4'b1010);
    @(negedge clk);
    en4 = 1'b0; in4 = 4'b0101;
    tick();
    check("w4_hold", out4, 4'b1010);
    @(negedge clk);
    en4 = 1'b1;
    tick();
    check("w4_load_inverse", out4, 4'b0101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
